clk_rst_ctrl: RTL and testbench

- Parametrised clock-enable, power-management clock and reset sequencer for the BA22 core subsystem.
- Holds the core clock disabled until the program image is loaded (`load_done_i`).
- After load, releases N reset domains in a staggered sequence after a programmable delay.
- Generates a divided PM clock for the Tick Timer, PIC and PMU registers, and implements the PM stall handshake that freezes the core clock enable.

---
 rtl/clk_rst_ctrl_if.sv | 24 ++
 rtl/clk_rst_ctrl.sv | 130 +++++++++++++
 tb/tb_clk_rst_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/clk_rst_ctrl_if.sv
// Control/status bundle between the BA22 subsystem and its clock/reset sequencer.
// The sequencer uses the slave modport; the system side drives the master modport.
interface clk_rst_ctrl_if #(
   parameter int N_RST = 2
) ();
   logic             load_done_i;
   logic             pm_stall_req_i;
   logic             pm_stalled_i;
   logic             clk_en_o;
   logic             pm_clk_o;
   logic [N_RST-1:0] rst_n_o;
   logic             pm_stall_o;
   logic             ready_o;

   modport master (
      output load_done_i, pm_stall_req_i, pm_stalled_i,
      input  clk_en_o, pm_clk_o, rst_n_o, pm_stall_o, ready_o
   );

   modport slave (
      input  load_done_i, pm_stall_req_i, pm_stalled_i,
      output clk_en_o, pm_clk_o, rst_n_o, pm_stall_o, ready_o
   );
endinterface

// File: rtl/clk_rst_ctrl.sv
// Core clock-enable, PM clock divider and staggered reset-domain sequencer.
// Holds the core until the image is loaded, then releases domains and handles PM stalls.
module clk_rst_ctrl #(
   parameter int PM_DIV      = 4,
   parameter int RST_DELAY   = 60,
   parameter int N_RST       = 2,
   parameter int RST_STAGGER = 4
) (
   input  logic          clk,
   input  logic          rst,
   clk_rst_ctrl_if.slave bus
);
   localparam int HALF   = PM_DIV / 2;
   localparam int DIV_W  = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int CNT_W  = $clog2(RST_DELAY + N_RST * RST_STAGGER + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RST_DELAY + N_RST * RST_STAGGER);

   typedef enum logic [2:0] {IDLE, DELAY, STAGGER, RUN, STALL_REQ, STALLED} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [N_RST-1:0] mask;
   logic [N_RST-1:0] rst_n;
   logic [DIV_W-1:0] div_cnt;
   logic             pm_clk;
   logic             clk_en;
   logic             stall;
   logic             ready;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   // Domain k is due once the post-load cycle count reaches RST_DELAY + k*RST_STAGGER.
   function automatic logic [N_RST-1:0] release_mask(input logic [CNT_W-1:0] c);
      logic [N_RST-1:0] m;
      m = '0;
      for (int k = 0; k < N_RST; k++)
         m[k] = (32'(c) >= 32'(RST_DELAY + k * RST_STAGGER));
      return m;
   endfunction

   assign cnt_nxt = sat_inc(cnt);
   assign mask    = release_mask(cnt_nxt);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         pm_clk  <= 1'b1;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         pm_clk  <= ~pm_clk;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         clk_en <= 1'b0;
         rst_n  <= '0;
         stall  <= 1'b0;
         ready  <= 1'b0;
      end else if (state != IDLE && !bus.load_done_i) begin
         // Losing the image drops everything back to the pre-load condition.
         state  <= IDLE;
         cnt    <= '0;
         clk_en <= 1'b0;
         rst_n  <= '0;
         stall  <= 1'b0;
         ready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.load_done_i) begin
                  state  <= DELAY;
                  cnt    <= '0;
                  clk_en <= 1'b1;
               end
            end
            DELAY, STAGGER: begin
               cnt   <= cnt_nxt;
               rst_n <= rst_n | mask;
               if (&mask) begin
                  state <= RUN;
                  ready <= 1'b1;
               end else if (mask[0]) begin
                  state <= STAGGER;
               end
            end
            RUN: begin
               if (bus.pm_stall_req_i) begin
                  state <= STALL_REQ;
                  stall <= 1'b1;
                  ready <= 1'b0;
               end
            end
            STALL_REQ: begin
               if (!bus.pm_stall_req_i) begin
                  state <= RUN;
                  stall <= 1'b0;
                  ready <= 1'b1;
               end else if (bus.pm_stalled_i) begin
                  state  <= STALLED;
                  clk_en <= 1'b0;
               end
            end
            STALLED: begin
               if (!bus.pm_stall_req_i) begin
                  state  <= RUN;
                  clk_en <= 1'b1;
                  stall  <= 1'b0;
                  ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.clk_en_o   = clk_en;
   assign bus.pm_clk_o   = pm_clk;
   assign bus.rst_n_o    = rst_n;
   assign bus.pm_stall_o = stall;
   assign bus.ready_o    = ready;
endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Directed bench: default sequencer (2 domains, 60-cycle delay) and a 4-domain
// variant (delay 5, stagger 2), with hand-computed expected outputs per edge.
module tb_clk_rst_ctrl;
   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int   checks = 0;
   int   failures = 0;

   clk_rst_ctrl_if #(.N_RST(2)) bus_a ();
   clk_rst_ctrl_if #(.N_RST(4)) bus_b ();

   clk_rst_ctrl dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a.slave)
   );

   clk_rst_ctrl #(
      .PM_DIV      (4),
      .RST_DELAY   (5),
      .N_RST       (4),
      .RST_STAGGER (2)
   ) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance past n rising edges and settle 1 time unit after the last one.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [3:0] exp_b [0:11];

   initial begin
      exp_b = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF};
      bus_a.load_done_i    = 1'b0;
      bus_a.pm_stall_req_i = 1'b0;
      bus_a.pm_stalled_i   = 1'b0;
      bus_b.load_done_i    = 1'b0;
      bus_b.pm_stall_req_i = 1'b0;
      bus_b.pm_stalled_i   = 1'b0;

      // Reset values
      tick(3);
      check("rst_clk_en", bus_a.clk_en_o, 0);
      check("rst_pm_clk", bus_a.pm_clk_o, 1);
      check("rst_rst_n", bus_a.rst_n_o, 0);
      check("rst_stall", bus_a.pm_stall_o, 0);
      check("rst_ready", bus_a.ready_o, 0);
      check("rst_b_rst_n", bus_b.rst_n_o, 0);
      rst_a = 1'b0;
      rst_b = 1'b0;

      // PM divider toggles at edges 2, 4, 6 after release
      tick(1); check("pm_e1", bus_a.pm_clk_o, 1);
      tick(1); check("pm_e2", bus_a.pm_clk_o, 0);
      tick(1); check("pm_e3", bus_a.pm_clk_o, 0);
      tick(1); check("pm_e4", bus_a.pm_clk_o, 1);
      tick(2); check("pm_e6", bus_a.pm_clk_o, 0);
      check("idle_clk_en", bus_a.clk_en_o, 0);

      // Load sequence
      bus_a.load_done_i = 1'b1;
      tick(1);
      check("e0_clk_en", bus_a.clk_en_o, 1);
      check("e0_rst_n", bus_a.rst_n_o, 0);
      tick(59);
      check("e59_rst_n", bus_a.rst_n_o, 0);
      check("e59_clk_en", bus_a.clk_en_o, 1);
      tick(1);
      check("e60_rst_n", bus_a.rst_n_o, 2'b01);
      check("e60_ready", bus_a.ready_o, 0);
      tick(3);
      check("e63_rst_n", bus_a.rst_n_o, 2'b01);
      check("e63_ready", bus_a.ready_o, 0);
      tick(1);
      check("e64_rst_n", bus_a.rst_n_o, 2'b11);
      check("e64_ready", bus_a.ready_o, 1);

      // Stall with acknowledge
      bus_a.pm_stall_req_i = 1'b1;
      tick(1);
      check("req_stall", bus_a.pm_stall_o, 1);
      check("req_ready", bus_a.ready_o, 0);
      check("req_clk_en", bus_a.clk_en_o, 1);
      tick(2);
      check("req_wait_clk_en", bus_a.clk_en_o, 1);
      bus_a.pm_stalled_i = 1'b1;
      tick(1);
      check("ack_clk_en", bus_a.clk_en_o, 0);
      check("ack_stall", bus_a.pm_stall_o, 1);
      bus_a.pm_stall_req_i = 1'b0;
      tick(1);
      check("unstall_clk_en", bus_a.clk_en_o, 1);
      check("unstall_ready", bus_a.ready_o, 1);
      check("unstall_stall", bus_a.pm_stall_o, 0);
      bus_a.pm_stalled_i = 1'b0;
      tick(1);

      // Stall request withdrawn before acknowledge
      bus_a.pm_stall_req_i = 1'b1;
      tick(1);
      check("wd_stall", bus_a.pm_stall_o, 1);
      check("wd_clk_en", bus_a.clk_en_o, 1);
      bus_a.pm_stall_req_i = 1'b0;
      tick(1);
      check("wd_stall_off", bus_a.pm_stall_o, 0);
      check("wd_ready", bus_a.ready_o, 1);
      check("wd_clk_en2", bus_a.clk_en_o, 1);

      // Load drop from RUN, then again mid-DELAY
      bus_a.load_done_i = 1'b0;
      tick(1);
      check("drop_run_rst_n", bus_a.rst_n_o, 0);
      check("drop_run_ready", bus_a.ready_o, 0);
      check("drop_run_clk_en", bus_a.clk_en_o, 0);
      bus_a.load_done_i = 1'b1;
      tick(1);
      check("e1_clk_en", bus_a.clk_en_o, 1);
      tick(29);
      bus_a.load_done_i = 1'b0;
      tick(1);
      check("drop_dly_clk_en", bus_a.clk_en_o, 0);
      check("drop_dly_rst_n", bus_a.rst_n_o, 0);
      bus_a.load_done_i = 1'b1;
      tick(1);
      check("e2_clk_en", bus_a.clk_en_o, 1);
      tick(59);
      check("e2_59_rst_n", bus_a.rst_n_o, 0);
      tick(1);
      check("e2_60_rst_n", bus_a.rst_n_o, 2'b01);

      // Four-domain staggered release
      bus_b.load_done_i = 1'b1;
      tick(1);
      check("b_e0_clk_en", bus_b.clk_en_o, 1);
      check("b_e0_rst_n", bus_b.rst_n_o, 0);
      for (int k = 1; k <= 11; k++) begin
         tick(1);
         check($sformatf("b_e%0d_rst_n", k), bus_b.rst_n_o, exp_b[k]);
         check($sformatf("b_e%0d_ready", k), bus_b.ready_o, (k == 11) ? 1 : 0);
      end

      // Restart and reset mid-STAGGER
      bus_b.load_done_i = 1'b0;
      tick(1);
      check("b_drop_rst_n", bus_b.rst_n_o, 0);
      bus_b.load_done_i = 1'b1;
      tick(8);
      check("b_mid_rst_n", bus_b.rst_n_o, 4'h3);
      rst_b = 1'b1;
      tick(1);
      check("b_rst_clk_en", bus_b.clk_en_o, 0);
      check("b_rst_pm_clk", bus_b.pm_clk_o, 1);
      check("b_rst_rst_n", bus_b.rst_n_o, 0);
      check("b_rst_stall", bus_b.pm_stall_o, 0);
      check("b_rst_ready", bus_b.ready_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
